coder_8to3: RTL and testbench

- Registered 8-to-3 binary encoder.
- Converts a one-hot (or multi-hot) 8-bit input vector X into the 3-bit index Y of the selected set bit.
- Also flags whether any bit is set and whether more than one bit is set.
- Sits between one-hot select/request sources and logic consuming a binary index.

---
 rtl/coder_8to3.sv | 63 ++++++
 tb/tb_coder_8to3.sv | 131 +++++++++++++
 2 files changed

// File: rtl/coder_8to3.sv
// Registered priority encoder: one-hot/multi-hot vector to binary index.
// Also flags whether any line is set and whether more than one line is set.
module coder_8to3 #(
    parameter int WIDTH        = 8,
    parameter int OUT_W        = 3,
    parameter bit MSB_PRIORITY = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] X,
    output logic [OUT_W-1:0] Y,
    output logic             valid,
    output logic             multi
);

    logic [OUT_W-1:0] y_d,     y_q;
    logic             valid_d, valid_q;
    logic             multi_d, multi_q;
    logic             seen;

    // Priority-select the winning index; the last match in scan order wins.
    always_comb begin
        y_d = '0;
        if (MSB_PRIORITY) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (X[i]) y_d = OUT_W'(i);
            end
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (X[i]) y_d = OUT_W'(i);
            end
        end
    end

    // Any-set and two-or-more-set flags from an OR chain, no adder.
    always_comb begin
        seen    = 1'b0;
        multi_d = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            multi_d = multi_d | (seen & X[i]);
            seen    = seen | X[i];
        end
        valid_d = seen;
    end

    // Output register, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q     <= '0;
            valid_q <= 1'b0;
            multi_q <= 1'b0;
        end else begin
            y_q     <= y_d;
            valid_q <= valid_d;
            multi_q <= multi_d;
        end
    end

    assign Y     = y_q;
    assign valid = valid_q;
    assign multi = multi_q;

endmodule

// File: tb/tb_coder_8to3.sv
// Bench for coder_8to3: both priority modes against an arithmetic model.
// Directed reset/boundary cases followed by random vectors.
module tb_coder_8to3;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] x     = 8'h00;
    logic [2:0] y_m, y_l;
    logic       v_m, v_l, m_m, m_l;
    int         errs   = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    coder_8to3 #(.WIDTH(8), .OUT_W(3), .MSB_PRIORITY(1'b1)) dut_msb (
        .clk(clk), .rst_n(rst_n), .X(x),
        .Y(y_m), .valid(v_m), .multi(m_m)
    );

    coder_8to3 #(.WIDTH(8), .OUT_W(3), .MSB_PRIORITY(1'b0)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .X(x),
        .Y(y_l), .valid(v_l), .multi(m_l)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // floor(log2(v)), 0 for v==0
    function automatic int hi_idx(input int v);
        int r = 0;
        while (v > 1) begin
            v = v / 2;
            r++;
        end
        return r;
    endfunction

    function automatic int lo_idx(input int v);
        if (v == 0) return 0;
        return hi_idx(v & (-v));
    endfunction

    function automatic int popc(input int v);
        int n = 0;
        while (v > 0) begin
            n += v % 2;
            v = v / 2;
        end
        return n;
    endfunction

    task automatic check_model(input string tag, input int v);
        check({tag, ".msb.y"}, 32'(y_m), 32'(hi_idx(v)));
        check({tag, ".msb.valid"}, 32'(v_m), 32'(v != 0));
        check({tag, ".msb.multi"}, 32'(m_m), 32'(popc(v) >= 2));
        check({tag, ".lsb.y"}, 32'(y_l), 32'(lo_idx(v)));
        check({tag, ".lsb.valid"}, 32'(v_l), 32'(v != 0));
        check({tag, ".lsb.multi"}, 32'(m_l), 32'(popc(v) >= 2));
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".msb"}, {29'd0, y_m, v_m, m_m}, 32'd0);
        check({tag, ".lsb"}, {29'd0, y_l, v_l, m_l}, 32'd0);
    endtask

    // drive v after an edge, check one edge later
    task automatic apply(input string tag, input logic [7:0] v);
        x = v;
        @(posedge clk);
        #1;
        check_model(tag, int'(v));
    endtask

    initial begin
        x     = 8'hFF;
        rst_n = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            check_zero("in_reset");
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_model("rst_release", 8'hFF);
        check("rst_release.y7", 32'(y_m), 32'd7);

        for (int i = 0; i < 8; i++) apply("walk", 8'(1 << i));

        apply("zero", 8'h00);
        apply("one_after_zero", 8'h01);
        apply("multi_26", 8'b0010_0110);
        check("multi_26.msb5", 32'(y_m), 32'd5);
        check("multi_26.lsb1", 32'(y_l), 32'd1);
        apply("all_ones", 8'hFF);
        apply("top_only", 8'h80);
        check("top_only.lsb7", 32'(y_l), 32'd7);

        apply("pre_reset", 8'h04);
        x = 8'h08;
        #2 rst_n = 1'b0;
        #1;
        check_zero("async_clear");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_zero("held_after_release");
        @(posedge clk);
        #1;
        check_model("resume", 8'h08);

        for (int i = 0; i < 200; i++) begin
            logic [7:0] r;
            r = 8'($urandom);
            if (i % 4 == 0) r = r & 8'($urandom);
            if (i % 9 == 0) r = 8'(1 << $urandom_range(7, 0));
            apply("rand", r);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
